// File: rtl/prefix_add_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder/subtractor.
package prefix_add_pkg;

    // Generate/propagate pair for one prefix position (single bit or a group).
    typedef struct packed {
        logic gen;
        logic prop;
    } gp_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Black cell: merge a higher group (hi) with the adjacent lower group (lo).
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.gen  = hi.gen | (hi.prop & lo.gen);
        r.prop = hi.prop & lo.prop;
        return r;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone prefix level: black cells at distance DIST plus pass-through.
// Vector index j holds bit position j-1, so index 0 is the carry-in slot (bit -1).
module prefix_level
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIST  = 1
) (
    input  logic [WIDTH:0] i_gen,
    input  logic [WIDTH:0] i_prop,
    output logic [WIDTH:0] o_gen,
    output logic [WIDTH:0] o_prop
);

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_pos
            if (gi >= DIST) begin : g_black
                gp_t w_hi;
                gp_t w_lo;
                gp_t w_out;
                assign w_hi   = {i_gen[gi], i_prop[gi]};
                assign w_lo   = {i_gen[gi-DIST], i_prop[gi-DIST]};
                assign w_out  = gp_combine(w_hi, w_lo);
                assign o_gen[gi]  = w_out.gen;
                assign o_prop[gi] = w_out.prop;
            end else begin : g_pass
                // Partner would lie below the carry-in slot: group is already complete.
                assign o_gen[gi]  = i_gen[gi];
                assign o_prop[gi] = i_prop[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/prefix_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with carry-in, flags, tag and
// valid/ready flow control. One input register stage plus one per prefix level.
module prefix_adder_pipe
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);

    // Stage registers: index 0 is the input register, 1..LEVELS the prefix levels.
    logic [WIDTH:0]   r_gen   [0:LEVELS];
    logic [WIDTH:0]   r_prop  [0:LEVELS];
    logic [WIDTH-1:0] r_half  [0:LEVELS];
    logic             r_amsb  [0:LEVELS];
    logic             r_bmsb  [0:LEVELS];
    logic [TAG_W-1:0] r_tag   [0:LEVELS];
    logic             r_valid [0:LEVELS];

    logic [WIDTH:0]   w_gen_lvl  [1:LEVELS];
    logic [WIDTH:0]   w_prop_lvl [1:LEVELS];

    logic [WIDTH-1:0] w_b;
    logic             w_c0;
    logic [WIDTH:0]   w_gen0;
    logic [WIDTH:0]   w_prop0;
    logic             w_stall;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    // Subtraction is A + ~B + 1; the carry-in becomes the generate of slot -1.
    assign w_b     = in_sub ? ~in_b : in_b;
    assign w_c0    = in_sub | in_cin;
    assign w_gen0  = {in_a & w_b, w_c0};
    assign w_prop0 = {in_a ^ w_b, 1'b0};

    // A result sitting on the output that the consumer refuses freezes everything.
    assign w_stall  = r_valid[LEVELS] & ~out_ready;
    assign in_ready = ~w_stall;

    genvar gi;
    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : g_level
            prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (gi - 1))
            ) u_level (
                .i_gen  (r_gen[gi-1]),
                .i_prop (r_prop[gi-1]),
                .o_gen  (w_gen_lvl[gi]),
                .o_prop (w_prop_lvl[gi])
            );
        end
    endgenerate

    // Pipeline advance: clear on reset, hold on stall, otherwise shift one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= LEVELS; s++) begin
                r_gen[s]   <= '0;
                r_prop[s]  <= '0;
                r_half[s]  <= '0;
                r_amsb[s]  <= 1'b0;
                r_bmsb[s]  <= 1'b0;
                r_tag[s]   <= '0;
                r_valid[s] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_gen[0]   <= w_gen0;
            r_prop[0]  <= w_prop0;
            r_half[0]  <= in_a ^ w_b;
            r_amsb[0]  <= in_a[WIDTH-1];
            r_bmsb[0]  <= w_b[WIDTH-1];
            r_tag[0]   <= in_tag;
            r_valid[0] <= in_valid;
            for (int s = 1; s <= LEVELS; s++) begin
                r_gen[s]   <= w_gen_lvl[s];
                r_prop[s]  <= w_prop_lvl[s];
                r_half[s]  <= r_half[s-1];
                r_amsb[s]  <= r_amsb[s-1];
                r_bmsb[s]  <= r_bmsb[s-1];
                r_tag[s]   <= r_tag[s-1];
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    // Index j of w_carry is the group generate ending at bit j-1, i.e. the carry into bit j.
    assign w_carry = r_gen[LEVELS];
    assign w_sum   = r_half[LEVELS] ^ w_carry[WIDTH-1:0];

    assign out_valid = r_valid[LEVELS];
    assign out_sum   = w_sum;
    // For power-of-two widths the MSB group spans bits 0..WIDTH-1 but stops short of
    // the carry-in slot, so fold c0 (always parked in index 0) in through the group propagate.
    assign out_cout  = w_carry[WIDTH] | (r_prop[LEVELS][WIDTH] & w_carry[0]);
    assign out_ovf   = (r_amsb[LEVELS] == r_bmsb[LEVELS]) && (w_sum[WIDTH-1] != r_amsb[LEVELS]);
    // Qualified by valid so an idle or freshly reset pipe does not flag zero.
    assign out_zero  = r_valid[LEVELS] & ~(|w_sum);
    assign out_tag   = r_tag[LEVELS];

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench: WIDTH=64/TAG_W=4 and WIDTH=8/TAG_W=2 instances, an
// arithmetic reference model with scoreboards, and directed literal checks.
module tb_prefix_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 64-bit instance signals
    logic        v64, r64i, ov64, ordy64, cin64, sub64, cout64, ovf64, zero64;
    logic [63:0] a64, b64, sum64;
    logic [3:0]  tag64, otag64;

    // 8-bit instance signals
    logic        v8, r8i, ov8, ordy8, cin8, sub8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  tag8, otag8;

    prefix_adder_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(v64), .in_ready(r64i), .in_a(a64), .in_b(b64),
        .in_cin(cin64), .in_sub(sub64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(ordy64), .out_sum(sum64),
        .out_cout(cout64), .out_ovf(ovf64), .out_zero(zero64), .out_tag(otag64)
    );

    prefix_adder_pipe #(.WIDTH(8), .TAG_W(2)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(r8i), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_sub(sub8), .in_tag(tag8),
        .out_valid(ov8), .out_ready(ordy8), .out_sum(sum8),
        .out_cout(cout8), .out_ovf(ovf8), .out_zero(zero8), .out_tag(otag8)
    );

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic [15:0]  tag;
        int           cyc;
    } exp_t;

    exp_t         q64[$];
    exp_t         q8[$];
    exp_t         e64, e8, em;
    logic [127:0] res_sum64[$];
    logic [15:0]  res_tag64[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                   input logic cin, input logic sub, input logic [15:0] tag);
        exp_t               e;
        logic [129:0]        mask, full;
        logic signed [129:0] sa, sb, sr, lim;
        mask = (130'd1 << w) - 130'd1;
        if (sub) begin
            full   = {2'b0, a} - {2'b0, b};
            e.cout = (a >= b);
        end else begin
            full   = {2'b0, a} + {2'b0, b} + {129'd0, cin};
            e.cout = full[w];
        end
        e.sum = full[127:0] & mask[127:0];
        sa = $signed({2'b0, a});
        sb = $signed({2'b0, b});
        if (a[w-1]) sa = sa - (130'sd1 <<< w);
        if (b[w-1]) sb = sb - (130'sd1 <<< w);
        sr  = sub ? (sa - sb) : (sa + sb + $signed({129'd0, cin}));
        lim = 130'sd1 <<< (w - 1);
        e.ovf  = (sr >= lim) || (sr < -lim);
        e.zero = (e.sum == 128'd0);
        e.tag  = tag;
        e.cyc  = 0;
        return e;
    endfunction

    // Compare process for the 64-bit instance: handshake rule, stall stability, scoreboard.
    logic        stall_prev64 = 1'b0;
    logic [63:0] sum_prev64;
    logic [3:0]  tag_prev64;
    always begin
        @(negedge clk);
        if (reset) begin
            q64.delete();
            stall_prev64 = 1'b0;
        end else begin
            check("in_ready64", r64i, !(ov64 && !ordy64));
            if (stall_prev64) begin
                check("hold_valid64", ov64, 1);
                check("hold_sum64", sum64, sum_prev64);
                check("hold_tag64", otag64, tag_prev64);
            end
            if (ov64 && ordy64) begin
                if (q64.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected64: result %0h tag %0h, expected no result", sum64, otag64);
                end else begin
                    e64 = q64.pop_front();
                    check("sum64", sum64, e64.sum);
                    check("cout64", cout64, e64.cout);
                    check("ovf64", ovf64, e64.ovf);
                    check("zero64", zero64, e64.zero);
                    check("tag64", otag64, e64.tag);
                    res_sum64.push_back(sum64);
                    res_tag64.push_back(otag64);
                end
            end
            stall_prev64 = ov64 && !ordy64;
            sum_prev64   = sum64;
            tag_prev64   = otag64;
            if (v64 && r64i) begin
                e64 = model(64, a64, b64, cin64, sub64, {12'd0, tag64});
                e64.cyc = cyc;
                q64.push_back(e64);
            end
        end
    end

    // Compare process for the 8-bit instance, including exact latency per result.
    always begin
        @(negedge clk);
        if (reset) begin
            q8.delete();
        end else begin
            if (ov8 && ordy8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected8: result %0h, expected no result", sum8);
                end else begin
                    e8 = q8.pop_front();
                    check("sum8", sum8, e8.sum);
                    check("cout8", cout8, e8.cout);
                    check("ovf8", ovf8, e8.ovf);
                    check("zero8", zero8, e8.zero);
                    check("tag8", otag8, e8.tag);
                    check("latency8", cyc - e8.cyc, 4);
                end
            end
            if (v8 && r8i) begin
                e8 = model(8, {120'd0, a8}, {120'd0, b8}, cin8, sub8, {14'd0, tag8});
                e8.cyc = cyc;
                q8.push_back(e8);
            end
        end
    end

    // Single 64-bit operation with the consumer always ready; returns edges to result.
    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, input logic [3:0] tag, output int lat);
        a64 = a; b64 = b; cin64 = cin; sub64 = sub; tag64 = tag;
        v64 = 1'b1; ordy64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        lat = 1;
        while (!ov64 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] blist [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h55, 8'h7E,
                               8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

    initial begin
        int lat, i, k, cnt;
        logic acc;
        reset = 1'b1;
        v64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; tag64 = 0; ordy64 = 1;
        v8 = 0;  a8 = 0;  b8 = 0;  cin8 = 0;  sub8 = 0;  tag8 = 0;  ordy8 = 1;

        // Pin the reference model with hand-computed values.
        em = model(64, 128'd5, 128'd7, 1'b0, 1'b1, 16'd0);
        check("model_sub_sum", em.sum, 128'hFFFF_FFFF_FFFF_FFFE);
        check("model_sub_cout", em.cout, 0);
        em = model(8, 128'h7F, 128'h01, 1'b0, 1'b0, 16'd0);
        check("model_ovf8", {em.ovf, em.cout, em.sum[7:0]}, 10'b10_1000_0000);
        em = model(8, 128'h03, 128'h03, 1'b1, 1'b1, 16'd0);
        check("model_zero8", {em.zero, em.cout, em.sum[7:0]}, 10'b11_0000_0000);

        // 1: reset for three edges, outputs all zero, then 0xFFFF...+1
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_out64", {ov64, sum64, cout64, ovf64, zero64, otag64}, '0);
            check("rst_out8", {ov8, sum8, cout8, ovf8, zero8, otag8}, '0);
        end
        reset = 1'b0;
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd3, lat);
        check("t1_latency", lat, 7);
        check("t1_result", {ov64, sum64, cout64, zero64, ovf64, otag64}, {1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 4'd3});

        // 2: 5 - 7
        run64(64'd5, 64'd7, 1'b0, 1'b1, 4'd4, lat);
        check("t2_latency", lat, 7);
        check("t2_result", {sum64, cout64, ovf64}, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});

        // 3: signed overflow in both directions
        run64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd5, lat);
        check("t3a_result", {sum64, ovf64, cout64}, {64'h8000_0000_0000_0000, 1'b1, 1'b0});
        run64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd6, lat);
        check("t3b_result", {sum64, ovf64, cout64}, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});

        // 4: stream of ten ops against out_ready pattern 1,0,0,1
        @(posedge clk); #1;
        res_sum64.delete(); res_tag64.delete();
        i = 0; k = 0;
        while ((i < 10 || q64.size() != 0 || ov64) && k < 200) begin
            ordy64 = pat[k % 4];
            if (i < 10) begin
                a64 = 64'(i); b64 = 64'(i); cin64 = i[0]; sub64 = 1'b0; tag64 = i[3:0]; v64 = 1'b1;
            end else begin
                v64 = 1'b0;
            end
            @(negedge clk);
            acc = v64 && r64i;
            @(posedge clk); #1;
            if (acc) i++;
            k++;
        end
        v64 = 1'b0; ordy64 = 1'b1;
        if (k >= 200) begin
            checks++; errors++;
            $display("FAIL t4_timeout: %0d ops accepted, expected 10 drained", i);
        end
        check("t4_count", res_sum64.size(), 10);
        for (int j = 0; j < 10 && j < res_sum64.size(); j++) begin
            check("t4_sum", res_sum64[j], 128'(2 * j + (j & 1)));
            check("t4_tag", res_tag64[j], 16'(j));
        end

        // 5: reset lands while ops are in flight
        for (int j = 0; j < 4; j++) begin
            a64 = 64'(100 + j); b64 = 64'd1; cin64 = 0; sub64 = 0; tag64 = 4'(j); v64 = 1'b1;
            reset = (j == 3);
            @(posedge clk); #1;
        end
        reset = 1'b0; v64 = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            check("t5_no_stale", ov64, 0);
        end
        run64(64'd10, 64'd20, 1'b1, 1'b0, 4'd9, lat);
        check("t5_new_op", {lat[7:0], sum64, otag64}, {8'd7, 64'd31, 4'd9});

        // 6: 8-bit sweep, back-to-back, latency and flags via the scoreboard
        cnt = 0;
        for (int a = 0; a < 256; a++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    a8 = 8'(a); b8 = blist[bi]; cin8 = m[0]; sub8 = m[1]; tag8 = cnt[1:0];
                    v8 = 1'b1;
                    cnt++;
                    @(posedge clk); #1;
                end
            end
        end
        v8 = 1'b0;
        k = 0;
        while ((q8.size() != 0 || q64.size() != 0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain64", q64.size(), 0);
        check("drain8", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
